// File: rtl/requant_ctrl_pkg.sv
// Shared types and constants for the requantize/pack datapath.
package dpu_pkg;

  localparam int WORD_W  = 32;   // packed output word width
  localparam int PACK    = 4;    // INT8 results per output word
  localparam int BYTE_W  = 8;
  localparam int ACC_W   = 32;   // signed accumulator width
  localparam int SCALE_W = 16;   // unsigned scale width
  localparam int CNT_W   = 21;   // element counter width (num_ch * num_pix)
  localparam int PROD_W  = ACC_W + SCALE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Saturate a wide signed value to the INT8 range [-128, 127].
  function automatic logic [BYTE_W-1:0] sat_s8(input logic signed [PROD_W-1:0] v);
    if (v > $signed(PROD_W'(127))) begin
      return 8'h7F;
    end else if (v < -$signed(PROD_W'(128))) begin
      return 8'h80;
    end else begin
      return v[BYTE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/requant_ctrl_requantize.sv
// One-cycle requantizer: floor(acc * scale >> SCALE_Q), saturated to INT8.
module requant_ctrl_requantize
  import dpu_pkg::*;
#(
  parameter int SCALE_Q = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic [SCALE_W-1:0]       scale_i,
  output logic                     done_o,
  output logic [BYTE_W-1:0]        result_o
);

  logic signed [PROD_W-1:0] acc_x;
  logic signed [PROD_W-1:0] scale_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic [BYTE_W-1:0]        result_d;
  logic                     done_q;
  logic [BYTE_W-1:0]        result_q;

  // Scale is unsigned, so it is zero-extended; the product always fits PROD_W.
  assign acc_x    = {{(PROD_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign scale_x  = {{(PROD_W-SCALE_W){1'b0}}, scale_i};
  assign prod     = acc_x * scale_x;
  assign shifted  = prod >>> SCALE_Q;   // arithmetic shift gives floor
  assign result_d = sat_s8(shifted);

  // Register the saturated result and its valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= valid_i;
      if (valid_i) begin
        result_q <= result_d;
      end
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: rtl/requant_ctrl.sv
// Tile controller: per-channel scale table, requantize stage and INT8 packer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid, once raised, holds with stable payload until accepted;
// ready may depend combinationally on the consumer's ready (in_ready follows
// out_ready) but never on the producer's valid.
module requant_ctrl
  import dpu_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int SCALE_Q = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_addr,
  input  logic [SCALE_W-1:0]          cfg_scale,
  input  logic                        start,
  input  logic [$clog2(NUM_CH):0]     num_ch,
  input  logic [15:0]                 num_pix,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [ACC_W-1:0]     in_acc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output state_t                      dbg_state
);

  localparam int AW = $clog2(NUM_CH);

  // FSM and tile counters
  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             start_acc;
  logic [AW:0]      num_ch_q;
  logic [AW-1:0]    ch_idx_q;
  logic [CNT_W-1:0] elem_left_q;
  logic             last_res_q;     // final element's result is in the requantizer

  // Scale table (not reset)
  logic [SCALE_W-1:0] table_q [NUM_CH];

  // Packer and output register
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [1:0]        lane_q, lane_d;
  logic              flush_q, flush_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              load;
  logic [WORD_W-1:0] load_data;
  logic              load_last;
  logic [WORD_W-1:0] merged;

  // Requantizer interface
  logic              req_done;
  logic [BYTE_W-1:0] req_result;

  logic              out_free;
  logic              out_fire;
  logic              in_fire;
  logic              tile_empty;
  logic [CNT_W-1:0]  tile_total;
  logic              ch_last;

  assign out_free   = !out_valid_q || out_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign in_ready   = (state_q == ST_RUN) && (elem_left_q != '0) && out_free;
  assign in_fire    = in_valid && in_ready;
  assign tile_empty = (num_ch == '0) || (num_pix == '0);
  assign tile_total = CNT_W'(num_ch) * CNT_W'(num_pix);
  assign ch_last    = ({1'b0, ch_idx_q} == (num_ch_q - (AW+1)'(1)));

  // Next-state logic; an empty tile only produces a done pulse.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tile_empty) begin
            done_d = 1'b1;
          end else begin
            start_acc = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_fire && (elem_left_q == CNT_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Tile shape capture, element countdown and channel index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_ch_q    <= '0;
      ch_idx_q    <= '0;
      elem_left_q <= '0;
      last_res_q  <= 1'b0;
    end else begin
      last_res_q <= in_fire && (elem_left_q == CNT_W'(1));
      if (start_acc) begin
        num_ch_q    <= num_ch;
        ch_idx_q    <= '0;
        elem_left_q <= tile_total;
      end else if (in_fire) begin
        elem_left_q <= elem_left_q - CNT_W'(1);
        if (ch_last) begin
          ch_idx_q <= '0;
        end else begin
          ch_idx_q <= ch_idx_q + AW'(1);
        end
      end
    end
  end

  // Scale table writes are accepted only while idle, freezing scales per tile.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == ST_IDLE)) begin
      table_q[cfg_addr] <= cfg_scale;
    end
  end

  requant_ctrl_requantize #(
    .SCALE_Q (SCALE_Q)
  ) u_requantize (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (in_fire),
    .acc_i    (in_acc),
    .scale_i  (table_q[ch_idx_q]),
    .done_o   (req_done),
    .result_o (req_result)
  );

  // Packer: fill lanes 0..3; a full word or the final partial word is loaded
  // into the output register. A full word never meets a stalled output
  // register because in_ready already required it to be free.
  always_comb begin
    buf_d     = buf_q;
    lane_d    = lane_q;
    flush_d   = flush_q;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    merged    = buf_q;
    merged[{lane_q, 3'b000} +: BYTE_W] = req_result;
    if (req_done) begin
      if (lane_q == 2'(PACK-1)) begin
        load      = 1'b1;
        load_data = merged;
        load_last = last_res_q;
        buf_d     = '0;
        lane_d    = '0;
      end else if (last_res_q) begin
        buf_d   = merged;
        lane_d  = lane_q + 2'd1;
        flush_d = 1'b1;
      end else begin
        buf_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end else if (flush_q && out_free) begin
      load      = 1'b1;
      load_data = buf_q;
      load_last = 1'b1;
      buf_d     = '0;
      lane_d    = '0;
      flush_d   = 1'b0;
    end
  end

  // Output register next state: load wins, otherwise drop after acceptance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_last_d  = load_last;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Packer and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q       <= '0;
      lane_q      <= '0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      lane_q      <= lane_d;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/requant_ctrl.md
REQUANT_CTRL -- requirements
Module: requant_ctrl

Interface
REQ-001 Parameter NUM_CH, default 16: depth of the per-channel scale table; maximum channels per tile.
REQ-002 Parameter SCALE_Q, default 16: fraction bits of scale, passed unchanged to the requantize instance.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cfg_we / cfg_addr / cfg_scale  in  1 / $clog2(NUM_CH) / 16  scale-table write port; cfg_scale is unsigned Q0.SCALE_Q.
REQ-006 start  in  1  one-cycle request to begin a tile.
REQ-007 num_ch / num_pix  in  $clog2(NUM_CH)+1 / 16  tile shape, sampled on an accepted start.
REQ-008 in_valid / in_ready / in_acc  in / out / in  1 / 1 / 32 signed  accumulator stream, channel-major within each pixel.
REQ-009 out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / 32 / 1  packed INT8 stream.
REQ-010 busy / done  out  1 / 1  busy high from accepted start through final word; done is a one-cycle pulse.

Function
REQ-011 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN once the last element has been accepted; DRAIN->IDLE when the final word is accepted by out_ready. done pulses in the cycle after that acceptance.
REQ-012 start while busy is ignored; start with num_ch==0 or num_pix==0 produces only a done pulse in the next cycle, with no output and busy staying low.
REQ-013 Total elements = num_ch*num_pix (21-bit counter); ch_idx wraps from num_ch-1 to 0 on each accepted element.
REQ-014 in_ready = (state==RUN) && elements_left>0 && (!out_valid || out_ready).
REQ-015 On an accepted element, in_acc and table[ch_idx] drive the requantize instance with valid=1; its result (floor of acc*scale >> SCALE_Q, clamped to [-128,127]) is available one cycle later on done.
REQ-016 Packer: results fill byte lanes 0,1,2,3 in order (lane 0 = out_data[7:0]); the 4th byte moves the word into the output register, which sets out_valid in the following cycle.
REQ-017 Final word: when the element count is not a multiple of 4, the final partial word is emitted in DRAIN with unused upper lanes set to 0x00; out_last is high only on the final word.
REQ-018 out_data, out_valid and out_last hold stable while out_valid && !out_ready; out_valid drops the cycle after acceptance unless the next word is loaded that same cycle.
REQ-019 cfg_we is ignored while busy (scales frozen for the whole tile); while idle, the write takes effect for the next start.
REQ-020 The design never drops or duplicates a byte under any out_ready pattern.

Reset
REQ-021 On rst_n low at a clock edge, the block enters IDLE and all outputs and state reset: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, all counters and the packer cleared.
REQ-022 Reset during RUN or DRAIN abandons the tile: no done pulse, and no further output until a new start.
REQ-023 The scale table is not reset; its contents are undefined until written.

Structure
REQ-024 The requant word width (32), the pack factor (4) and the FSM state enum live in dpu_pkg.
REQ-025 Exactly one requantize sub-module is instantiated, with its rst_n tied to the block rst_n; the table and packer are inline.

Verification
REQ-026 Case 1: table[0]=0x8000, num_ch=1, num_pix=4, acc {200,256,-300,-3} -> one word 0xFE80_7F64 with out_last=1, then done.
REQ-027 Case 2: num_ch=3 with scales {0x8000,0x4000,0x2000}, num_pix=2, all acc=400 -> bytes 200→127,100,50,127,100,50; words 0x7F32_647F and 0x0000_3264, the second with out_last=1.
REQ-028 Case 3: random out_ready at 30%, 64 elements -> 16 words matching the golden model, none lost or duplicated, and out_data stable throughout every stall.
REQ-029 Case 4: start pulsed again mid-tile and cfg_we pulsed while busy -> the tile is unaffected and the table is unchanged.
REQ-030 Case 5: rst_n asserted low after 5 accepted elements -> next cycle all outputs are 0, no done pulse; a following tile is correct.
REQ-031 Case 6: num_pix=0 -> a done pulse one cycle after start, with no out_valid and busy held at 0.
